acc_drain: RTL and testbench
============================

ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 SHALL have parameter N, default 16, meaning number of accumulator results captured per drain.
REQ-002 SHALL have parameter D_W_ACC, default 32, meaning width of each signed accumulator result.
REQ-003 SHALL have parameter D_OUT, default 8, meaning width of each signed output word.
REQ-004 SHALL have parameter SHIFT, default 0, meaning arithmetic right-shift applied before width reduction.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port capture  input  1  one-cycle request to sample all results.
REQ-008 SHALL have port acc_result  input  N*D_W_ACC  packed signed results, element i at bits [i*D_W_ACC +: D_W_ACC].
REQ-009 SHALL have port out_valid  output  1  output word valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts word.
REQ-011 SHALL have port out_data  output  D_OUT  signed reduced word.
REQ-012 SHALL have port out_idx  output  $clog2(N)  element index of out_data.
REQ-013 SHALL have port out_last  output  1  high on element N-1.
REQ-014 SHALL have port out_sat  output  1  current word was clamped.
REQ-015 SHALL have port busy  output  1  drain in progress.
REQ-016 SHALL have port overrun  output  1  sticky: capture lost.
REQ-017 SHALL have port clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-018 SHALL implement two states, IDLE and STREAM; busy equals (state == STREAM); out_valid equals busy.
REQ-019 SHALL, in IDLE with capture high, copy all N acc_result elements into a shadow bank, set index to 0 and enter STREAM next cycle (first word valid one cycle after capture).
REQ-020 SHALL present shadow element [index], reduced per REQ-024/REQ-025, on out_data, with out_idx = index, out_last = (index == N-1).
REQ-021 SHALL advance index by one only on a cycle with out_valid && out_ready; out_data, out_idx, out_last and out_sat SHALL stay stable while out_valid && !out_ready.
REQ-022 SHALL, on handshake of the out_last word, return to IDLE; if capture is high in that same cycle, it SHALL instead reload the shadow bank, reset index to 0 and stay in STREAM with no bubble.
REQ-023 SHALL ignore capture in STREAM outside the REQ-022 cycle, leaving the shadow bank unchanged and setting overrun; overrun SHALL clear only on clr_overrun or rst, with set taking priority over a simultaneous clear.
REQ-024 SHALL arithmetic-right-shift each element by SHIFT (truncation toward negative infinity) before width reduction.
REQ-025 SHALL perform width reduction per REQ-030/REQ-031.
REQ-026 SHALL handle N == 1 with out_last constantly high during STREAM.

Reset
REQ-027 SHALL, on rst, asynchronously force state IDLE, index 0, busy 0, out_valid 0, out_last 0, out_sat 0, and overrun 0.
REQ-028 SHALL clear out_data and out_idx to 0 on rst; the shadow bank need not be reset.
REQ-029 SHALL abandon any drain on rst mid-STREAM; no word SHALL be presented until a fresh capture.

Configuration
REQ-030 SHALL, with macro ACC_DRAIN_SAT_EN defined, clamp the shifted value to [-2^(D_OUT-1), 2^(D_OUT-1)-1] and raise out_sat for clamped words.
REQ-031 SHALL, without ACC_DRAIN_SAT_EN, take the low D_OUT bits of the shifted value and hold out_sat at 0.

Structure
REQ-032 SHALL place the state enum (IDLE, STREAM) and default width constants in shared package acc_pkg.
REQ-033 SHALL implement shift plus reduction in one combinational sub-module, acc_requant, instantiated once on the selected element.

Verification
REQ-034 SHALL cover: N=4, SHIFT=0, results {1,-2,3,-4}, capture, out_ready=1 -> words 1,-2,3,-4 on cycles 1..4, out_last on idx 3, busy low on cycle 5.
REQ-035 SHALL cover: out_ready held low 3 cycles on idx 1 -> out_data and out_idx stable, no word skipped or repeated.
REQ-036 SHALL cover: capture during idx 1 -> overrun=1, stream unchanged; capture with last handshake -> new words start next cycle, no gap.
REQ-037 SHALL cover: with ACC_DRAIN_SAT_EN, D_OUT=8, SHIFT=2, value 1000 -> out_data 127 with out_sat=1; value -9 -> -3 with out_sat=0; without macro, 1000 -> low byte of 250 (-6).
REQ-038 SHALL cover: rst asserted mid-STREAM at idx 2 -> out_valid, busy and overrun low immediately; no words until next capture.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and default sizing for the accumulator drain block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int N_DEF       = 16;
    localparam int D_W_ACC_DEF = 32;
    localparam int D_OUT_DEF   = 8;
    localparam int SHIFT_DEF   = 0;

    // Index width; a single-element bank still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_drain_if.sv
// Output word stream of acc_drain: valid/ready handshake plus word side-band.
// Latency: n/a (wires only).
// Backpressure: master holds all fields stable while out_valid && !out_ready.
// Ports: out_valid/out_data/out_idx/out_last/out_sat from master, out_ready from slave.
interface acc_drain_if
    import acc_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int D_OUT = D_OUT_DEF
) ();
    localparam int IW = idx_w(N);

    logic             out_valid;
    logic             out_ready;
    logic [D_OUT-1:0] out_data;
    logic [IW-1:0]    out_idx;
    logic             out_last;
    logic             out_sat;

    modport master (
        output out_valid, out_data, out_idx, out_last, out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_last, out_sat,
        output out_ready
    );
endinterface

// File: rtl/acc_requant.sv
// Requantizer: arithmetic right shift, then width reduction to D_OUT bits.
// Latency: combinational.
// Backpressure: none (pure function of val_i).
// Ports: val_i signed accumulator element; data_o reduced word; sat_o word was clamped.
// Macro ACC_DRAIN_SAT_EN selects clamping; without it the low D_OUT bits are kept.
module acc_requant
    import acc_pkg::*;
#(
    parameter int D_W_ACC = D_W_ACC_DEF,
    parameter int D_OUT   = D_OUT_DEF,
    parameter int SHIFT   = SHIFT_DEF
) (
    input  logic signed [D_W_ACC-1:0] val_i,
    output logic        [D_OUT-1:0]   data_o,
    output logic                      sat_o
);
    // >>> on a signed operand rounds toward negative infinity.
    logic signed [D_W_ACC-1:0] shifted;
    assign shifted = val_i >>> SHIFT;

`ifdef ACC_DRAIN_SAT_EN
    // Value fits when every bit from the output sign position upward matches the sign.
    logic fits;
    assign fits = (shifted[D_W_ACC-1:D_OUT-1] == {(D_W_ACC-D_OUT+1){shifted[D_W_ACC-1]}});

    always_comb begin
        data_o = shifted[D_OUT-1:0];
        sat_o  = 1'b0;
        if (!fits) begin
            sat_o  = 1'b1;
            data_o = {shifted[D_W_ACC-1], {(D_OUT-1){~shifted[D_W_ACC-1]}}};
        end
    end
`else
    // Upper bits are deliberately discarded in wrap mode.
    logic unused_hi;
    assign unused_hi = ^shifted;
    assign data_o    = shifted[D_OUT-1:0];
    assign sat_o     = 1'b0;
`endif
endmodule

// File: rtl/acc_drain.sv
// Captures N accumulator results into a shadow bank and streams them out one word per handshake.
// Latency: first word valid one cycle after capture; back-to-back reload on last handshake, no bubble.
// Backpressure: out_ready low stalls the stream with all word fields held; capture while busy sets overrun.
// Ports: clk, rst (async, active-high), capture, acc_result, dout (acc_drain_if master),
//        busy, overrun (sticky), clr_overrun. Macro ACC_DRAIN_SAT_EN enables saturation in acc_requant.
module acc_drain
    import acc_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int D_W_ACC = D_W_ACC_DEF,
    parameter int D_OUT   = D_OUT_DEF,
    parameter int SHIFT   = SHIFT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic [N*D_W_ACC-1:0] acc_result,
    acc_drain_if.master          dout,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 clr_overrun
);
    localparam int            IW       = idx_w(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           overrun_q, overrun_d;
    logic           load;
    logic           ovr_set;
    logic           hs;
    logic           at_last;

    logic [D_W_ACC-1:0] shadow_q [N];

    logic [D_OUT-1:0] req_data;
    logic             req_sat;

    assign hs      = (state_q == STREAM) && dout.out_ready;
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs && at_last) begin
                    idx_d = '0;
                    // A capture coinciding with the final handshake chains straight into a new drain.
                    if (capture) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs) begin
                        idx_d = idx_q + IW'(1);
                    end
                    ovr_set = capture;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Setting wins over a same-cycle clear.
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Shadow bank carries data only; it is never observed outside STREAM, so it has no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= acc_result[i*D_W_ACC +: D_W_ACC];
            end
        end
    end

    acc_requant #(
        .D_W_ACC (D_W_ACC),
        .D_OUT   (D_OUT),
        .SHIFT   (SHIFT)
    ) u_requant (
        .val_i  (shadow_q[idx_q]),
        .data_o (req_data),
        .sat_o  (req_sat)
    );

    // Word fields are gated by STREAM so reset forces them to zero without resetting the bank.
    assign busy           = (state_q == STREAM);
    assign overrun        = overrun_q;
    assign dout.out_valid = busy;
    assign dout.out_idx   = idx_q;
    assign dout.out_data  = busy ? req_data : '0;
    assign dout.out_last  = busy && at_last;
    assign dout.out_sat   = busy && req_sat;
endmodule

// File: tb/tb_acc_drain.sv
module tb_acc_drain;
    import acc_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int DO  = 8;
    localparam int SH0 = 0;
    localparam int SH1 = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              capture;
    logic              clr_overrun;
    logic              ready;
    logic [N*DW-1:0]   acc_result;
    logic              busy0, busy1, ovr0, ovr1;

    acc_drain_if #(.N(N), .D_OUT(DO)) if0 ();
    acc_drain_if #(.N(N), .D_OUT(DO)) if1 ();

    assign if0.out_ready = ready;
    assign if1.out_ready = ready;

    always #5 clk = ~clk;

    acc_drain #(.N(N), .D_W_ACC(DW), .D_OUT(DO), .SHIFT(SH0)) dut0 (
        .clk(clk), .rst(rst), .capture(capture), .acc_result(acc_result),
        .dout(if0), .busy(busy0), .overrun(ovr0), .clr_overrun(clr_overrun)
    );

    acc_drain #(.N(N), .D_W_ACC(DW), .D_OUT(DO), .SHIFT(SH1)) dut1 (
        .clk(clk), .rst(rst), .capture(capture), .acc_result(acc_result),
        .dout(if1), .busy(busy1), .overrun(ovr1), .clr_overrun(clr_overrun)
    );

    // Reference model: a queue of pending words plus a sticky overrun flag.
    typedef struct {
        longint val;
        int     idx;
    } word_t;

    word_t mq[$];
    bit    m_ovr;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic longint elem(input int i);
        logic signed [DW-1:0] e;
        e = acc_result[i*DW +: DW];
        return longint'(e);
    endfunction

    // Floor division by 2^sh, then clamp or wrap to DO bits; returns the DO-bit pattern.
    function automatic void reduce(input longint v, input int sh,
                                   output logic [63:0] d, output logic [63:0] s);
        longint p, q, mx, mn;
        p  = longint'(1) <<< sh;
        q  = v / p;
        if (v < 0 && q * p != v) q = q - 1;
        mx = (longint'(1) <<< (DO - 1)) - 1;
        mn = -(longint'(1) <<< (DO - 1));
        s  = 64'd0;
`ifdef ACC_DRAIN_SAT_EN
        if (q > mx) begin
            q = mx;
            s = 64'd1;
        end else if (q < mn) begin
            q = mn;
            s = 64'd1;
        end
`else
        if (q > mx || q < mn) s = 64'd0;
`endif
        d = 64'(q) & ((64'd1 << DO) - 64'd1);
    endfunction

    task automatic model_clock();
        bit was_busy, hs, set;
        was_busy = (mq.size() > 0);
        hs       = was_busy && ready;
        if (hs) void'(mq.pop_front());
        set = 1'b0;
        if (capture) begin
            if (!was_busy || (hs && mq.size() == 0)) begin
                for (int i = 0; i < N; i++) mq.push_back('{val: elem(i), idx: i});
            end else begin
                set = 1'b1;
            end
        end
        if (set) m_ovr = 1'b1;
        else if (clr_overrun) m_ovr = 1'b0;
    endtask

    task automatic compare_all(input string ph);
        bit          v;
        logic [63:0] d0, s0, d1, s1;
        v = (mq.size() > 0);
        check({ph, ":valid0"}, 64'(if0.out_valid), 64'(v));
        check({ph, ":valid1"}, 64'(if1.out_valid), 64'(v));
        check({ph, ":busy0"},  64'(busy0), 64'(v));
        check({ph, ":busy1"},  64'(busy1), 64'(v));
        check({ph, ":ovr0"},   64'(ovr0),  64'(m_ovr));
        check({ph, ":ovr1"},   64'(ovr1),  64'(m_ovr));
        if (v) begin
            reduce(mq[0].val, SH0, d0, s0);
            reduce(mq[0].val, SH1, d1, s1);
            check({ph, ":data0"}, 64'(if0.out_data), d0);
            check({ph, ":sat0"},  64'(if0.out_sat),  s0);
            check({ph, ":idx0"},  64'(if0.out_idx),  64'(mq[0].idx));
            check({ph, ":last0"}, 64'(if0.out_last), 64'(mq[0].idx == N - 1));
            check({ph, ":data1"}, 64'(if1.out_data), d1);
            check({ph, ":sat1"},  64'(if1.out_sat),  s1);
            check({ph, ":idx1"},  64'(if1.out_idx),  64'(mq[0].idx));
            check({ph, ":last1"}, 64'(if1.out_last), 64'(mq[0].idx == N - 1));
        end
    endtask

    // Called at a falling edge: drive, let one rising edge happen, check at the next falling edge.
    task automatic step(input string ph, input bit cap, input bit rdy, input bit clr);
        capture     = cap;
        ready       = rdy;
        clr_overrun = clr;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all(ph);
    endtask

    task automatic set_res(input int a0, input int a1, input int a2, input int a3);
        acc_result[0*DW +: DW] = a0;
        acc_result[1*DW +: DW] = a1;
        acc_result[2*DW +: DW] = a2;
        acc_result[3*DW +: DW] = a3;
    endtask

    task automatic rand_res();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) acc_result[i*DW +: DW] = $urandom();
            else acc_result[i*DW +: DW] = DW'($urandom_range(0, 4000)) - DW'(2000);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        capture     = 1'b0;
        clr_overrun = 1'b0;
        ready       = 1'b0;
        acc_result  = '0;
        m_ovr       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:valid", 64'(if0.out_valid), 64'd0);
        check("rst:busy",  64'(busy0), 64'd0);
        check("rst:ovr",   64'(ovr0),  64'd0);
        check("rst:idx",   64'(if0.out_idx),  64'd0);
        check("rst:data",  64'(if0.out_data), 64'd0);
        check("rst:last",  64'(if0.out_last), 64'd0);
        check("rst:sat",   64'(if0.out_sat),  64'd0);
        rst = 1'b0;
        step("idle", 0, 1, 0);

        // Basic drain of {1,-2,3,-4} with ready held high.
        set_res(1, -2, 3, -4);
        step("basic", 1, 1, 0);
        check("basic:first", 64'(if0.out_data), 64'h01);
        for (int i = 0; i < 4; i++) step("basic", 0, 1, 0);
        check("basic:done", 64'(busy0), 64'd0);

        // Stall three cycles on idx 1.
        step("stall", 1, 1, 0);
        step("stall", 0, 1, 0);
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 0);
        for (int i = 0; i < 4; i++) step("stall", 0, 1, 0);

        // Capture mid-stream sets overrun; capture on last handshake chains with no gap.
        step("ovr", 1, 1, 0);
        step("ovr", 0, 1, 0);
        set_res(7, 8, 9, 10);
        step("ovr", 1, 0, 0);
        check("ovr:sticky", 64'(ovr0), 64'd1);
        step("ovr", 0, 1, 0);
        step("ovr", 0, 1, 0);
        step("chain", 1, 1, 0);
        check("chain:idx", 64'(if0.out_idx), 64'd0);
        check("chain:data", 64'(if0.out_data), 64'd7);
        step("chain", 1, 1, 1);
        step("chain", 0, 1, 1);
        for (int i = 0; i < 3; i++) step("chain", 0, 1, 0);

        // Requantization corner values on the SHIFT=2 instance.
        set_res(1000, -9, -1000, 5);
        step("rq", 1, 0, 0);
`ifdef ACC_DRAIN_SAT_EN
        check("rq:1000", 64'(if1.out_data), 64'h7F);
        check("rq:1000s", 64'(if1.out_sat), 64'd1);
`else
        check("rq:1000", 64'(if1.out_data), 64'hFA);
        check("rq:1000s", 64'(if1.out_sat), 64'd0);
`endif
        step("rq", 0, 1, 0);
        check("rq:-9", 64'(if1.out_data), 64'hFD);
        check("rq:-9s", 64'(if1.out_sat), 64'd0);
        for (int i = 0; i < 3; i++) step("rq", 0, 1, 0);

        // Reset in the middle of a drain at idx 2, with overrun set.
        set_res(11, 12, 13, 14);
        step("mrst", 1, 1, 0);
        step("mrst", 1, 1, 0);
        step("mrst", 0, 1, 0);
        check("mrst:idx", 64'(if0.out_idx), 64'd2);
        rst = 1'b1;
        #1;
        mq.delete();
        m_ovr = 1'b0;
        check("mrst:valid", 64'(if0.out_valid), 64'd0);
        check("mrst:busy",  64'(busy0), 64'd0);
        check("mrst:ovr",   64'(ovr0),  64'd0);
        check("mrst:busy1", 64'(busy1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("mrst", 0, 1, 0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 1500; c++) begin
            rand_res();
            step("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
